ad_serial_resp: RTL and testbench
=================================

Name: ad_serial_resp

Overview:
- ADC-side responder for the per-channel cs_n/sclk/sdata serial link; emulates an AD7276-style 12-bit converter.
- The channel reader can then be exercised on-board in loopback without a physical ADC.
- Runs on the system clock. Oversamples the externally driven cs_n and sclk, and shifts out a framed sample MSB-first.
- Sample source is either an external port or an internal ramp, for self-test.

Parameters:
- DW, 12, sample width in bits.
- LEAD, 4, leading zero bits before sample MSB.
- FRAME, 16, total bits per frame; must be ≥ LEAD+DW, with trailing zeros padding the rest.
- SYNC_STG, 2, synchronizer depth for cs_n and sclk.

Ports:
- clk_sys  in  1  system clock; must be ≥8x the sclk frequency.
- rst  in  1  synchronous active-high reset.
- cs_n  in  1  chip select from reader, asynchronous to clk_sys.
- sclk  in  1  serial clock from reader, asynchronous, idles high.
- sdata  out  1  serial data to reader.
- sdata_oe  out  1  drive enable for the pad tristate; 1 only inside a frame.
- ramp_en  in  1  1 = internal ramp source, 0 = external sample.
- sample_in  in  DW  external sample.
- sample_vld  in  1  one-cycle strobe; loads sample_in into the shadow register.
- frame_done  out  1  one-cycle pulse when a complete frame ends.
- frame_cnt  out  16  count of complete frames, wraps.
- short_err  out  1  sticky: cs_n rose before the full frame.
- underrun_err  out  1  sticky: external mode frame loaded with no new sample since the previous load.
- err_clr  in  1  clears both sticky flags.

Behaviour:
Reset values:
- Synchronous reset. sdata=0, sdata_oe=0, frame_done=0, frame_cnt=0, both flags 0, shadow=0, state IDLE.
- Synchronizer stages reset to 1. armed=0.

Input conditioning:
- cs_n and sclk each pass through SYNC_STG flops, then a 1-flop edge detector.
- armed is set once synchronized cs_n=1 has been seen. This means a cs_n held low across reset release never starts a frame.

IDLE:
- sdata_oe=0, sdata=0.
- On a synchronized cs_n fall with armed=1:
  - Load shift register = {LEAD zeros, shadow, FRAME-LEAD-DW zeros}.
  - sdata=MSB, sdata_oe=1, edge_cnt=0, go to SHIFT.
  - If ramp_en=0 and no sample_vld since the last load, set underrun_err.

Latency:
- From cs_n pin fall to sdata valid is SYNC_STG+2 clk_sys cycles.

SHIFT:
- On each synchronized sclk fall: shift left by 1, fill with 0, edge_cnt++ saturating at FRAME.
- sdata changes only on these edges. The reader samples on sclk rise.
- After FRAME-1 falls, sdata holds 0 until cs_n rises.
- sclk edges while cs_n is high are ignored.

cs_n rise in SHIFT:
- Go to IDLE; sdata_oe=0 on the following cycle.
- If edge_cnt ≥ FRAME-1: frame_done pulses, frame_cnt++ (16-bit wrap).
  - If ramp_en=1, shadow increments modulo 2^DW.
- Otherwise set short_err; no count and no ramp step.

Shadow register:
- sample_vld loads sample_in when ramp_en=0.
- If sample_vld coincides with the load cycle, the frame uses the previous shadow value and the new sample is kept for the next frame.
- In ramp mode sample_vld is ignored.

Flags:
- err_clr clears both flags. If err_clr and a new error occur in the same cycle, set wins.

Reset mid-frame:
- Immediate IDLE, sdata_oe=0, partial frame discarded, no flag set.

Test Plan:
- ramp_en=0, sample_vld with 12'hA5C, 16-sclk frame at clk_sys/10 -> bits sampled on sclk rise = 0000_1010_0101_1100; frame_done 1 pulse; frame_cnt=1; sdata_oe low within SYNC_STG+2 cycles after cs_n rise.
- ramp_en=1 from reset, 4097 full frames -> decoded values 0,1,…,4095,0; frame_cnt=4097; no flags.
- cs_n raised after 8 sclk falls -> short_err=1; frame_cnt unchanged; next full frame decodes correctly. err_clr pulse -> short_err=0.
- ramp_en=0, two frames with no sample_vld between them -> underrun_err=1 on the second cs_n fall; second frame repeats the first value.
- sample_vld (12'h123) on the same cycle as the load, shadow=12'h321 -> frame carries 12'h321; next frame carries 12'h123 with no underrun.
- rst asserted mid-SHIFT while cs_n stays low -> sdata_oe=0 next cycle; no frame starts until cs_n goes high and falls again.

Source files
------------

// File: rtl/ad_serial_resp_if.sv
// Serial link between the channel reader (master) and the ADC responder (slave).
interface ad_serial_resp_if;
    logic cs_n;
    logic sclk;
    logic sdata;
    logic sdata_oe;

    modport master (output cs_n, output sclk, input sdata, input sdata_oe);
    modport slave  (input cs_n, input sclk, output sdata, output sdata_oe);
endinterface

// File: rtl/ad_serial_resp.sv
// AD7276-style serial ADC responder: oversamples cs_n/sclk on clk_sys and shifts
// a zero-framed sample out MSB-first, from an external port or an internal ramp.
module ad_serial_resp #(
    parameter int unsigned DW       = 12,
    parameter int unsigned LEAD     = 4,
    parameter int unsigned FRAME    = 16,
    parameter int unsigned SYNC_STG = 2
) (
    input  logic                clk_sys,
    input  logic                rst,
    ad_serial_resp_if.slave     link,
    input  logic                ramp_en,
    input  logic [DW-1:0]       sample_in,
    input  logic                sample_vld,
    output logic                frame_done,
    output logic [15:0]         frame_cnt,
    output logic                short_err,
    output logic                underrun_err,
    input  logic                err_clr
);

    localparam int unsigned TRAIL = FRAME - LEAD - DW;
    localparam int unsigned CW    = $clog2(FRAME + 1);
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);
    localparam logic [CW-1:0] FULL = CW'(FRAME);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state;
    logic [SYNC_STG-1:0] cs_sync;
    logic [SYNC_STG-1:0] sc_sync;
    logic [SYNC_STG:0]   sync_vld;
    logic                cs_d;
    logic                sc_d;
    logic                cs_fall_q;
    logic                cs_rise_q;
    logic                sc_fall_q;
    logic                armed;
    logic [DW-1:0]       shadow;
    logic                fresh;
    logic [FRAME-2:0]    shreg;
    logic [CW-1:0]       edge_cnt;
    logic [FRAME-1:0]    load_word;
    logic                cs_s;
    logic                sc_s;
    logic                ext_load;

    assign cs_s      = cs_sync[SYNC_STG-1];
    assign sc_s      = sc_sync[SYNC_STG-1];
    assign load_word = FRAME'(shadow) << TRAIL;
    assign ext_load  = sample_vld && !ramp_en;

    // The synchronizer resets to 1, so its output is only trusted once sync_vld
    // has walked a 1 through every stage; otherwise a cs_n held low across reset
    // release would look like a fresh falling edge.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            cs_sync   <= '1;
            sc_sync   <= '1;
            sync_vld  <= '0;
            cs_d      <= 1'b1;
            sc_d      <= 1'b1;
            cs_fall_q <= 1'b0;
            cs_rise_q <= 1'b0;
            sc_fall_q <= 1'b0;
            armed     <= 1'b0;
        end else begin
            cs_sync[0] <= link.cs_n;
            sc_sync[0] <= link.sclk;
            for (int unsigned i = 1; i < SYNC_STG; i++) begin
                cs_sync[i] <= cs_sync[i-1];
                sc_sync[i] <= sc_sync[i-1];
            end
            sync_vld  <= {sync_vld[SYNC_STG-1:0], 1'b1};
            cs_d      <= cs_s;
            sc_d      <= sc_s;
            armed     <= armed | (sync_vld[SYNC_STG-1] & cs_s);
            cs_fall_q <= sync_vld[SYNC_STG] & armed & cs_d & ~cs_s;
            cs_rise_q <= sync_vld[SYNC_STG] & ~cs_d & cs_s;
            sc_fall_q <= sync_vld[SYNC_STG] & sc_d & ~sc_s;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state         <= IDLE;
            link.sdata    <= 1'b0;
            link.sdata_oe <= 1'b0;
            frame_done    <= 1'b0;
            frame_cnt     <= '0;
            short_err     <= 1'b0;
            underrun_err  <= 1'b0;
            shadow        <= '0;
            fresh         <= 1'b0;
            shreg         <= '0;
            edge_cnt      <= '0;
        end else begin
            frame_done <= 1'b0;
            if (ext_load) begin
                shadow <= sample_in;
                fresh  <= 1'b1;
            end
            // Clear first so a same-cycle error assignment below takes priority.
            if (err_clr) begin
                short_err    <= 1'b0;
                underrun_err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    link.sdata    <= 1'b0;
                    link.sdata_oe <= 1'b0;
                    if (cs_fall_q) begin
                        shreg         <= load_word[FRAME-2:0];
                        link.sdata    <= load_word[FRAME-1];
                        link.sdata_oe <= 1'b1;
                        edge_cnt      <= '0;
                        state         <= SHIFT;
                        if (!ext_load) fresh <= 1'b0;
                        if (!ramp_en && !fresh) underrun_err <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (cs_rise_q) begin
                        state         <= IDLE;
                        link.sdata    <= 1'b0;
                        link.sdata_oe <= 1'b0;
                        if (edge_cnt >= LAST) begin
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 16'd1;
                            if (ramp_en) shadow <= shadow + 1'b1;
                        end else begin
                            short_err <= 1'b1;
                        end
                    end else if (sc_fall_q) begin
                        link.sdata <= shreg[FRAME-2];
                        shreg      <= {shreg[FRAME-3:0], 1'b0};
                        if (edge_cnt != FULL) edge_cnt <= edge_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ad_serial_resp.sv
// Bench for ad_serial_resp: table of frames plus hand-written corner sequences,
// with decoded serial words checked through an expected-word queue.
module tb_ad_serial_resp;

    localparam int unsigned SYNC_STG = 2;
    localparam int unsigned HALF     = 4;

    typedef struct {
        logic        ramp;
        logic        load;
        logic [11:0] sample;
        int unsigned nf;
        logic        dn;
        logic [15:0] word;
        logic [15:0] cnt;
        logic        shrt;
        logic        under;
    } vec_t;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic        ramp_en;
    logic [11:0] sample_in;
    logic        sample_vld;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        short_err;
    logic        underrun_err;
    logic        err_clr;

    int          errors = 0;
    int          checks = 0;
    int          done_pulses = 0;
    logic [15:0] sb_q[$];
    vec_t        vecs[11];

    ad_serial_resp_if link ();

    ad_serial_resp #(.DW(12), .LEAD(4), .FRAME(16), .SYNC_STG(SYNC_STG)) dut (
        .clk_sys      (clk_sys),
        .rst          (rst),
        .link         (link),
        .ramp_en      (ramp_en),
        .sample_in    (sample_in),
        .sample_vld   (sample_vld),
        .frame_done   (frame_done),
        .frame_cnt    (frame_cnt),
        .short_err    (short_err),
        .underrun_err (underrun_err),
        .err_clr      (err_clr)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) if (frame_done) done_pulses <= done_pulses + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int unsigned n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic run_frame(input int unsigned nf, input logic vld_at_load,
                             input logic [11:0] vld_val, input logic clr_at_load,
                             input logic exp_done, input logic [15:0] exp_word);
        logic [15:0] got;
        logic [15:0] exp;
        int          d0;
        got = '0;
        d0  = done_pulses;
        if (exp_done) sb_q.push_back(exp_word);
        link.cs_n = 1'b0;
        wait_cyc(SYNC_STG + 1);
        check("oe_before_load", link.sdata_oe, 1'b0);
        sample_in  = vld_val;
        sample_vld = vld_at_load;
        err_clr    = clr_at_load;
        wait_cyc(1);
        sample_vld = 1'b0;
        err_clr    = 1'b0;
        check("oe_at_load", link.sdata_oe, 1'b1);
        wait_cyc(HALF);
        for (int unsigned i = 0; i < nf; i++) begin
            got[15-i] = link.sdata;
            link.sclk = 1'b0;
            wait_cyc(HALF);
            link.sclk = 1'b1;
            wait_cyc(HALF);
        end
        link.cs_n = 1'b1;
        wait_cyc(SYNC_STG + 2);
        check("oe_after_rise", link.sdata_oe, 1'b0);
        wait_cyc(2);
        check("done_pulses", done_pulses - d0, {31'd0, exp_done});
        if (exp_done) begin
            exp = sb_q.pop_front();
            check("word", got, exp);
        end
    endtask

    task automatic clear_flags();
        err_clr = 1'b1;
        wait_cyc(1);
        err_clr = 1'b0;
        check("short_cleared", short_err, 1'b0);
        check("under_cleared", underrun_err, 1'b0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 12'h000, 16, 1'b1, 16'h0000, 16'd1,  1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 12'h000, 16, 1'b1, 16'h0001, 16'd2,  1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 12'h000, 8,  1'b0, 16'h0000, 16'd2,  1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 12'h000, 16, 1'b1, 16'h0002, 16'd3,  1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 12'hA5C, 16, 1'b1, 16'h0A5C, 16'd4,  1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 12'h000, 16, 1'b1, 16'h0A5C, 16'd5,  1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 12'hFFD, 16, 1'b1, 16'h0FFD, 16'd6,  1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 12'h000, 16, 1'b1, 16'h0FFD, 16'd7,  1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 12'h000, 16, 1'b1, 16'h0FFE, 16'd8,  1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 12'h000, 16, 1'b1, 16'h0FFF, 16'd9,  1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 12'h000, 16, 1'b1, 16'h0000, 16'd10, 1'b0, 1'b0};

        rst        = 1'b1;
        link.cs_n  = 1'b1;
        link.sclk  = 1'b1;
        ramp_en    = 1'b1;
        sample_in  = '0;
        sample_vld = 1'b0;
        err_clr    = 1'b0;
        wait_cyc(5);
        check("rst_sdata", link.sdata, 1'b0);
        check("rst_oe", link.sdata_oe, 1'b0);
        check("rst_done", frame_done, 1'b0);
        check("rst_cnt", frame_cnt, 16'd0);
        check("rst_short", short_err, 1'b0);
        check("rst_under", underrun_err, 1'b0);
        rst = 1'b0;
        wait_cyc(SYNC_STG + 4);

        for (int unsigned k = 0; k < 11; k++) begin
            ramp_en = vecs[k].ramp;
            if (vecs[k].load) begin
                sample_in  = vecs[k].sample;
                sample_vld = 1'b1;
                wait_cyc(1);
                sample_vld = 1'b0;
                wait_cyc(1);
            end
            run_frame(vecs[k].nf, 1'b0, 12'h000, 1'b0, vecs[k].dn, vecs[k].word);
            check("vec_cnt", frame_cnt, vecs[k].cnt);
            check("vec_short", short_err, vecs[k].shrt);
            check("vec_under", underrun_err, vecs[k].under);
            clear_flags();
        end

        // Sample arriving on the load cycle goes to the next frame.
        ramp_en    = 1'b0;
        sample_in  = 12'h321;
        sample_vld = 1'b1;
        wait_cyc(1);
        sample_vld = 1'b0;
        wait_cyc(1);
        run_frame(16, 1'b1, 12'h123, 1'b0, 1'b1, 16'h0321);
        check("coinc_under1", underrun_err, 1'b0);
        run_frame(16, 1'b0, 12'h000, 1'b0, 1'b1, 16'h0123);
        check("coinc_under2", underrun_err, 1'b0);
        check("coinc_cnt", frame_cnt, 16'd12);
        // err_clr on the same cycle as a new underrun: the set wins.
        run_frame(16, 1'b0, 12'h000, 1'b1, 1'b1, 16'h0123);
        check("set_wins_under", underrun_err, 1'b1);
        clear_flags();

        // Reset in the middle of a frame with cs_n held low.
        ramp_en   = 1'b1;
        link.cs_n = 1'b0;
        wait_cyc(SYNC_STG + 2);
        check("mid_oe_on", link.sdata_oe, 1'b1);
        for (int unsigned i = 0; i < 3; i++) begin
            link.sclk = 1'b0;
            wait_cyc(HALF);
            link.sclk = 1'b1;
            wait_cyc(HALF);
        end
        rst = 1'b1;
        wait_cyc(1);
        check("mid_rst_oe", link.sdata_oe, 1'b0);
        check("mid_rst_cnt", frame_cnt, 16'd0);
        rst = 1'b0;
        for (int unsigned i = 0; i < 2; i++) begin
            link.sclk = 1'b0;
            wait_cyc(HALF);
            link.sclk = 1'b1;
            wait_cyc(HALF);
        end
        check("held_low_oe", link.sdata_oe, 1'b0);
        check("held_low_short", short_err, 1'b0);
        link.cs_n = 1'b1;
        wait_cyc(SYNC_STG + 4);
        check("cs_high_oe", link.sdata_oe, 1'b0);
        check("cs_high_cnt", frame_cnt, 16'd0);
        run_frame(16, 1'b0, 12'h000, 1'b0, 1'b1, 16'h0000);
        check("post_rst_cnt", frame_cnt, 16'd1);
        check("post_rst_short", short_err, 1'b0);
        check("post_rst_under", underrun_err, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
